// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the GPIO byte-bus arbiter: FSM encoding, GPIO register
// addresses and a small address helper.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StHold   = 2'd3
    } state_e;

    // GPIO chip register map (byte addresses)
    localparam logic [5:0] ADDR_UART_DATA = 6'd10;
    localparam logic [5:0] ADDR_TMR_CAP   = 6'd14;
    localparam logic [5:0] ADDR_PAIR0     = 6'd15;

    // Next byte of a 16-bit pair; the 6-bit address space wraps 63 -> 0.
    function automatic logic [5:0] addr_inc(input logic [5:0] a);
        return a + 6'd1;
    endfunction

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Requester handshakes plus GPIO chip pins. 'master' is the arbiter's view,
// 'slave' is the environment's view (requesters and chip).
interface gpio_bus_arbiter_if;
    logic        r0_valid, r0_ready, r0_we, r0_wide, r0_lock, r0_rsp_valid;
    logic [5:0]  r0_addr;
    logic [15:0] r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_we, r1_wide, r1_lock, r1_rsp_valid;
    logic [5:0]  r1_addr;
    logic [15:0] r1_wdata, r1_rdata;
    logic [5:0]  bus_addr;
    logic        bus_ceb, bus_oeb, bus_web, bus_doe;
    logic [7:0]  bus_dout, bus_din;

    modport master (
        input  r0_valid, r0_we, r0_wide, r0_lock, r0_addr, r0_wdata,
        output r0_ready, r0_rsp_valid, r0_rdata,
        input  r1_valid, r1_we, r1_wide, r1_lock, r1_addr, r1_wdata,
        output r1_ready, r1_rsp_valid, r1_rdata,
        output bus_addr, bus_ceb, bus_oeb, bus_web, bus_doe, bus_dout,
        input  bus_din
    );

    modport slave (
        output r0_valid, r0_we, r0_wide, r0_lock, r0_addr, r0_wdata,
        input  r0_ready, r0_rsp_valid, r0_rdata,
        output r1_valid, r1_we, r1_wide, r1_lock, r1_addr, r1_wdata,
        input  r1_ready, r1_rsp_valid, r1_rdata,
        input  bus_addr, bus_ceb, bus_oeb, bus_web, bus_doe, bus_dout,
        output bus_din
    );
endinterface

// File: rtl/gpio_arb_rr.sv
// Two-way round-robin picker. A held lock reserves the grant for its owner.
module gpio_arb_rr (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    input  logic       i_lock_active,
    input  logic       i_lock_owner,
    output logic [1:0] o_grant
);
    // One-hot grant: lock owner only, else pointer on contention, else sole valid
    always_comb begin
        o_grant = 2'b00;
        if (i_lock_active) begin
            o_grant[i_lock_owner] = i_valid[i_lock_owner];
        end else if (&i_valid) begin
            o_grant[i_ptr] = 1'b1;
        end else begin
            o_grant = i_valid;
        end
    end
endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-requester master for the GPIO chip's async-SRAM-style byte bus.
// 16-bit accesses run as an unbroken low/high byte pair with CEb held low.
// Optional build macro: GPIO_ARB_LOCK_EN (requester lock keeps the next grant).
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 1,
    parameter int unsigned RD_STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC      = 1
) (
    input logic                 clk_i,
    input logic                 reset,
    gpio_bus_arbiter_if.master  io_bus
);
    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we, r_wide, r_hi, r_owner, r_ptr, r_rsp0, r_rsp1;
    logic [5:0]  r_addr;
    logic [15:0] r_wdata, r_rdata;
    logic [1:0]  w_grant;
    logic        w_accept, w_win, w_win_lock, w_lock_active, w_lock_owner;
    logic        w_sample, w_pair_step, w_finish, w_doe;

    gpio_arb_rr u_rr (
        .i_valid       ({io_bus.r1_valid, io_bus.r0_valid}),
        .i_ptr         (r_ptr),
        .i_lock_active (w_lock_active),
        .i_lock_owner  (w_lock_owner),
        .o_grant       (w_grant)
    );

    assign w_accept   = (r_state == StIdle) && (|w_grant);
    assign w_win      = w_grant[1];
    assign w_win_lock = w_win ? io_bus.r1_lock : io_bus.r0_lock;

`ifdef GPIO_ARB_LOCK_EN
    logic r_locked, r_lock_owner;

    // Lock follows the lock bit of every accepted transaction
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_locked     <= 1'b0;
            r_lock_owner <= 1'b0;
        end else if (w_accept) begin
            r_locked     <= w_win_lock;
            r_lock_owner <= w_win;
        end
    end

    assign w_lock_active = r_locked;
    assign w_lock_owner  = r_lock_owner;
`else
    logic w_unused_lock;
    assign w_unused_lock = w_win_lock;
    assign w_lock_active = 1'b0;
    assign w_lock_owner  = 1'b0;
`endif

    // Next state and phase counter; write strobe is always a single cycle
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sample     = 1'b0;
        w_pair_step  = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StSetup;
                    w_cnt_next   = 4'd0;
                end
            end
            StSetup: begin
                if (r_cnt == 4'(SETUP_CYC - 1)) begin
                    w_state_next = StStrobe;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StStrobe: begin
                if (r_we || (r_cnt == 4'(RD_STROBE_CYC - 1))) begin
                    w_state_next = StHold;
                    w_cnt_next   = 4'd0;
                    w_sample     = !r_we;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StHold: begin
                if (r_cnt == 4'(HOLD_CYC - 1)) begin
                    w_cnt_next = 4'd0;
                    if (r_wide && !r_hi) begin
                        w_state_next = StSetup;
                        w_pair_step  = 1'b1;
                    end else begin
                        w_state_next = StIdle;
                        w_finish     = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, latched request, rr pointer, read assembly and response pulse
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_wide  <= 1'b0;
            r_hi    <= 1'b0;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_addr  <= 6'd0;
            r_wdata <= 16'h0000;
            r_rdata <= 16'h0000;
            r_rsp0  <= 1'b0;
            r_rsp1  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rsp0  <= w_finish && !r_owner;
            r_rsp1  <= w_finish && r_owner;
            if (w_accept) begin
                r_owner <= w_win;
                r_we    <= w_win ? io_bus.r1_we    : io_bus.r0_we;
                r_wide  <= w_win ? io_bus.r1_wide  : io_bus.r0_wide;
                r_addr  <= w_win ? io_bus.r1_addr  : io_bus.r0_addr;
                r_wdata <= w_win ? io_bus.r1_wdata : io_bus.r0_wdata;
                r_hi    <= 1'b0;
                r_rdata <= 16'h0000;
                // A locking accept keeps the pointer where it is
                if (!(w_lock_active || w_win_lock) || !w_win_lock) begin
                    r_ptr <= !w_win;
                end
            end
            if (w_pair_step) begin
                r_addr <= addr_inc(r_addr);
                r_hi   <= 1'b1;
            end
            if (w_sample) begin
                if (r_hi) r_rdata[15:8] <= io_bus.bus_din;
                else      r_rdata[7:0]  <= io_bus.bus_din;
            end
        end
    end

    assign w_doe = (r_state != StIdle) && r_we;

    // Pin drive: OEb and WEb are decoded from the single STROBE state, never both low
    always_comb begin
        io_bus.bus_addr = r_addr;
        io_bus.bus_ceb  = (r_state == StIdle);
        io_bus.bus_oeb  = !((r_state == StStrobe) && !r_we);
        io_bus.bus_web  = !((r_state == StStrobe) && r_we);
        io_bus.bus_doe  = w_doe;
        io_bus.bus_dout = w_doe ? (r_hi ? r_wdata[15:8] : r_wdata[7:0]) : 8'h00;
    end

    assign io_bus.r0_ready     = w_accept && !w_win;
    assign io_bus.r1_ready     = w_accept && w_win;
    assign io_bus.r0_rsp_valid = r_rsp0;
    assign io_bus.r1_rsp_valid = r_rsp1;
    assign io_bus.r0_rdata     = r_rdata;
    assign io_bus.r1_rdata     = r_rdata;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a byte-wide chip model on the pins.
// Lock sequence is compiled only when GPIO_ARB_LOCK_EN is defined.
module tb_gpio_bus_arbiter;
    import gpio_arb_pkg::*;

    typedef struct {
        int          req;
        logic        we;
        logic        wide;
        logic [5:0]  addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
        int          ceb_n;
        int          oeb_n;
        int          web_n;
        logic [5:0]  wa0;
        logic [7:0]  wd0;
        logic [5:0]  wa1;
        logic [7:0]  wd1;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem [64];
    int         checks = 0;
    int         errors = 0;
    int         ceb_n, oeb_n, web_n, wn;
    logic [5:0] wa [4];
    logic [7:0] wd [4];

    gpio_bus_arbiter_if u_if ();

    gpio_bus_arbiter u_dut (
        .clk_i  (clk_i),
        .reset  (reset),
        .io_bus (u_if)
    );

    always #5 clk_i = ~clk_i;

    // Chip model: combinational read data while OEb is low
    assign u_if.bus_din = u_if.bus_oeb ? 8'h00 : mem[u_if.bus_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Pin monitor on the falling edge; also commits chip writes
    always @(negedge clk_i) begin
        if (!reset) begin
            if (!u_if.bus_ceb) ceb_n++;
            if (!u_if.bus_oeb) oeb_n++;
            if (!u_if.bus_ceb) chk("oeb/web exclusive", {31'd0, !u_if.bus_oeb && !u_if.bus_web}, 0);
            if (!u_if.bus_web) begin
                web_n++;
                chk("doe on write strobe", {31'd0, u_if.bus_doe}, 1);
                if (wn < 4) begin
                    wa[wn] = u_if.bus_addr;
                    wd[wn] = u_if.bus_dout;
                end
                mem[u_if.bus_addr] = u_if.bus_dout;
                wn++;
            end
        end
    end

    task automatic clear_mon();
        ceb_n = 0; oeb_n = 0; web_n = 0; wn = 0;
    endtask

    task automatic drive(input int r, input logic v, input logic we, input logic wide,
                         input logic [5:0] addr, input logic [15:0] wdata, input logic lk);
        if (r == 0) begin
            u_if.r0_valid = v; u_if.r0_we = we; u_if.r0_wide = wide;
            u_if.r0_addr = addr; u_if.r0_wdata = wdata; u_if.r0_lock = lk;
        end else begin
            u_if.r1_valid = v; u_if.r1_we = we; u_if.r1_wide = wide;
            u_if.r1_addr = addr; u_if.r1_wdata = wdata; u_if.r1_lock = lk;
        end
    endtask

    function automatic logic rdy(input int r);
        return (r == 0) ? u_if.r0_ready : u_if.r1_ready;
    endfunction

    function automatic logic rsp(input int r);
        return (r == 0) ? u_if.r0_rsp_valid : u_if.r1_rsp_valid;
    endfunction

    // Waits (bounded) until requester r sees ready; sampled 1 ns after a falling edge
    task automatic wait_ready(input int r, input string nm);
        int n = 0;
        #1;
        while (!rdy(r) && n < 60) begin
            @(negedge clk_i); #1; n++;
        end
        chk({nm, " ready"}, {31'd0, rdy(r)}, 1);
    endtask

    // Counts rising edges after the accept edge until rsp_valid is seen (bounded)
    task automatic wait_rsp(input int r, output int lat);
        lat = 0;
        do begin
            @(posedge clk_i); #1; lat++;
        end while (!rsp(r) && lat < 40);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk_i);
        drive(v.req, 1'b1, v.we, v.wide, v.addr, v.wdata, 1'b0);
        wait_ready(v.req, nm);
        @(posedge clk_i); #1;
        drive(v.req, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        clear_mon();
        wait_rsp(v.req, lat);
        chk({nm, " latency"}, lat, v.lat);
        chk({nm, " ceb low cycles"}, ceb_n, v.ceb_n);
        chk({nm, " oeb low cycles"}, oeb_n, v.oeb_n);
        chk({nm, " web low cycles"}, web_n, v.web_n);
        if (!v.we) chk({nm, " rdata"}, {16'd0, (v.req == 0) ? u_if.r0_rdata : u_if.r1_rdata},
                       {16'd0, v.rdata});
        if (v.web_n >= 1) chk({nm, " write0"}, {18'd0, wa[0], wd[0]}, {18'd0, v.wa0, v.wd0});
        if (v.web_n >= 2) chk({nm, " write1"}, {18'd0, wa[1], wd[1]}, {18'd0, v.wa1, v.wd1});
    endtask

    vec_t vecs [7];
    int   exp_order [6];

    initial begin
        int lat, acc, cyc, g0, g1, hold_rdy, rsp_n;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[4] = 8'hC3; mem[10] = 8'h11; mem[15] = 8'h34; mem[16] = 8'h12;
        mem[63] = 8'h77; mem[0] = 8'h88;
        clear_mon();
        drive(0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);

        // req we wide addr wdata lat rdata ceb oeb web wa0 wd0 wa1 wd1
        vecs[0] = '{0, 1, 0, 6'd2,  16'h005A, 3, 16'h0000, 3, 0, 1, 6'd2,  8'h5A, 6'd0,  8'h00};
        vecs[1] = '{1, 0, 0, 6'd4,  16'h0000, 4, 16'h00C3, 4, 2, 0, 6'd0,  8'h00, 6'd0,  8'h00};
        vecs[2] = '{0, 0, 1, ADDR_PAIR0, 16'h0000, 8, 16'h1234, 8, 4, 0, 6'd0, 8'h00, 6'd0, 8'h00};
        vecs[3] = '{1, 1, 1, 6'd20, 16'hA55A, 6, 16'h0000, 6, 0, 2, 6'd20, 8'h5A, 6'd21, 8'hA5};
        vecs[4] = '{0, 0, 0, 6'd2,  16'h0000, 4, 16'h005A, 4, 2, 0, 6'd0,  8'h00, 6'd0,  8'h00};
        vecs[5] = '{1, 0, 1, 6'd63, 16'h0000, 8, 16'h8877, 8, 4, 0, 6'd0,  8'h00, 6'd0,  8'h00};
        vecs[6] = '{0, 0, 0, 6'd21, 16'h0000, 4, 16'h00A5, 4, 2, 0, 6'd0,  8'h00, 6'd0,  8'h00};
        exp_order = '{0, 1, 0, 1, 0, 1};

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset ceb/oeb/web", {29'd0, u_if.bus_ceb, u_if.bus_oeb, u_if.bus_web}, 32'h7);
        chk("reset doe", {31'd0, u_if.bus_doe}, 0);
        chk("reset addr", {26'd0, u_if.bus_addr}, 0);
        chk("reset dout", {24'd0, u_if.bus_dout}, 0);
        chk("reset rsp", {30'd0, u_if.r0_rsp_valid, u_if.r1_rsp_valid}, 0);
        chk("reset rdata", {u_if.r0_rdata, u_if.r1_rdata}, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Wide write wrapping 63 -> 0; r1 must stay off the bus until r0 completes
        @(negedge clk_i);
        drive(0, 1'b1, 1'b1, 1'b1, 6'd63, 16'hBEEF, 1'b0);
        wait_ready(0, "wrap write");
        @(posedge clk_i); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0, ADDR_UART_DATA, 16'h0, 1'b0);
        clear_mon();
        lat = 0; hold_rdy = 0;
        do begin
            if (u_if.r1_ready) hold_rdy++;
            @(posedge clk_i); #1; lat++;
        end while (!u_if.r0_rsp_valid && lat < 40);
        chk("wrap latency", lat, 6);
        chk("wrap r1 held off", hold_rdy, 0);
        chk("wrap ceb continuous", ceb_n, 6);
        chk("wrap byte lo", {18'd0, wa[0], wd[0]}, {18'd0, 6'd63, 8'hEF});
        chk("wrap byte hi", {18'd0, wa[1], wd[1]}, {18'd0, 6'd0, 8'hBE});
        chk("r1 ready in rsp cycle", {31'd0, u_if.r1_ready}, 1);
        @(posedge clk_i); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        wait_rsp(1, lat);
        chk("r1 after wrap latency", lat, 4);
        chk("r1 after wrap rdata", {16'd0, u_if.r1_rdata}, 32'h0011);

        // Contention: both valid for six grants, must alternate starting with r0
        @(negedge clk_i);
        drive(0, 1'b1, 1'b0, 1'b0, 6'd4, 16'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0, ADDR_UART_DATA, 16'h0, 1'b0);
        #1;
        acc = 0; cyc = 0; g0 = 0; g1 = 0;
        while (acc < 6 && cyc < 200) begin
            if (u_if.r0_ready || u_if.r1_ready) begin
                chk($sformatf("rr grant %0d", acc), u_if.r1_ready ? 1 : 0, exp_order[acc]);
                if (u_if.r0_ready) g0++; else g1++;
                acc++;
                if (acc == 6) break;
            end
            @(negedge clk_i); #1; cyc++;
        end
        chk("rr accepts", acc, 6);
        chk("rr r0 count", g0, 3);
        chk("rr r1 count", g1, 3);
        @(posedge clk_i); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        wait_rsp(1, lat);
        chk("rr last rdata", {16'd0, u_if.r1_rdata}, 32'h0011);

        // Reset during a read strobe
        @(negedge clk_i);
        drive(0, 1'b1, 1'b0, 1'b0, 6'd4, 16'h0, 1'b0);
        wait_ready(0, "pre-reset read");
        @(posedge clk_i); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        @(posedge clk_i); #1;
        chk("in strobe before reset", {31'd0, u_if.bus_oeb}, 0);
        reset = 1'b1;
        @(posedge clk_i); #1;
        chk("mid reset ceb/oeb/web", {29'd0, u_if.bus_ceb, u_if.bus_oeb, u_if.bus_web}, 32'h7);
        chk("mid reset doe", {31'd0, u_if.bus_doe}, 0);
        chk("mid reset addr", {26'd0, u_if.bus_addr}, 0);
        reset = 1'b0;
        rsp_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (u_if.r0_rsp_valid || u_if.r1_rsp_valid) rsp_n++;
            @(posedge clk_i); #1;
        end
        chk("no rsp after reset", rsp_n, 0);
        drive(0, 1'b1, 1'b0, 1'b0, 6'd4, 16'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0, ADDR_UART_DATA, 16'h0, 1'b0);
        #1;
        chk("post-reset grant r0", {30'd0, u_if.r0_ready, u_if.r1_ready}, 32'h2);
        @(posedge clk_i); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        wait_rsp(0, lat);
        chk("post-reset read rdata", {16'd0, u_if.r0_rdata}, 32'h00C3);

`ifdef GPIO_ARB_LOCK_EN
        // r0 locks with a capture write, then its read must win over a waiting r1
        @(negedge clk_i);
        drive(0, 1'b1, 1'b1, 1'b0, ADDR_TMR_CAP, 16'h0001, 1'b1);
        wait_ready(0, "lock write");
        @(posedge clk_i); #1;
        drive(0, 1'b1, 1'b0, 1'b0, 6'd27, 16'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0, ADDR_UART_DATA, 16'h0, 1'b0);
        cyc = 0;
        while (!(u_if.r0_ready || u_if.r1_ready) && cyc < 60) begin
            @(negedge clk_i); #1; cyc++;
        end
        chk("locked grant to r0", {30'd0, u_if.r0_ready, u_if.r1_ready}, 32'h2);
        @(posedge clk_i); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        wait_ready(1, "r1 after unlock");
        @(posedge clk_i); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        wait_rsp(1, lat);
        chk("r1 after unlock rsp", {31'd0, u_if.r1_rsp_valid}, 1);
`endif

        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
